// File: rtl/llc_trace_pkg.sv
// Shared types and ASCII helpers for the cache event trace writer.
// Records are serialised as "<op> <hex address>\n".
package llc_trace_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_LA    = 8'h61;
  localparam logic [7:0] CH_UA    = 8'h41;

  localparam int unsigned OP_MAX     = 9;
  localparam int unsigned REC_OP_W   = 4;
  localparam int unsigned REC_ADDR_W = 32;

  typedef struct packed {
    logic [REC_OP_W-1:0]   op;
    logic [REC_ADDR_W-1:0] addr;
  } trace_rec_t;

  typedef enum logic [2:0] {
    StIdle,
    StOp,
    StSpace,
    StHex,
    StEol
  } wr_state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
    if (nibble < 4'd10) begin
      return CH_ZERO + {4'h0, nibble};
    end
    return (upper ? CH_UA : CH_LA) + {4'h0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// Synchronous record FIFO with full/empty flags; pointers carry one extra wrap bit.
// Push while full and pop while empty are ignored.
module trace_rec_fifo
  import llc_trace_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type rec_t = trace_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rec_t wdata_i,
  input  logic pop_i,
  output rec_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          do_push, do_pop;
  rec_t          mem_q [Depth];

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q + {{PtrW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{PtrW{1'b0}}, do_pop};
    rdata_o = mem_q[rptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/trace_writer.sv
// Serialises cache event records into ASCII trace lines, one byte per accepted cycle.
// A record FIFO decouples bursty event posting from the byte-rate sink.
module trace_writer
  import llc_trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          UPPER_HEX  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              busy,
  output logic              drop_err,
  output logic [15:0]       rec_count
);

  localparam int unsigned NDig = ADDR_W / 4;
  localparam int unsigned CntW = $clog2(NDig + 1);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } rec_t;

  wr_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_sh;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              drop_q, drop_d;
  logic [15:0]       rec_count_q, rec_count_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic in_fire, op_bad, accept;
  rec_t push_rec, head;

  trace_rec_fifo #(
    .Depth (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (push_rec),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    in_ready  = !fifo_full;
    in_fire   = in_valid && in_ready;
    op_bad    = (32'(in_op) > OP_MAX);
    fifo_push = in_fire && !op_bad;
    drop_d    = in_fire && op_bad;
    push_rec  = '{op: in_op, addr: in_addr};
    accept    = out_valid_q && out_ready;
    cnt_dec   = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
    addr_sh   = addr_q >> {cnt_dec, 2'b00};

    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rec_count_d = rec_count_q;
    fifo_pop    = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          addr_d      = head.addr;
          out_byte_d  = CH_ZERO + 8'(head.op);
          out_valid_d = 1'b1;
          state_d     = StOp;
        end
      end
      StOp: begin
        if (accept) begin
          out_byte_d = CH_SPACE;
          state_d    = StSpace;
        end
      end
      StSpace: begin
        if (accept) begin
          out_byte_d = nibble_to_ascii(addr_q[ADDR_W-1 -: 4], UPPER_HEX);
          cnt_d      = CntW'(NDig - 1);
          state_d    = StHex;
        end
      end
      StHex: begin
        if (accept) begin
          if (cnt_q != '0) begin
            cnt_d      = cnt_dec;
            out_byte_d = nibble_to_ascii(addr_sh[3:0], UPPER_HEX);
          end else begin
            out_byte_d = CH_NL;
            out_last_d = 1'b1;
            state_d    = StEol;
          end
        end
      end
      StEol: begin
        if (accept) begin
          rec_count_d = rec_count_q + 16'd1;
          out_last_d  = 1'b0;
          // Chain straight into the next line so back-to-back records have no bubble.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            addr_d     = head.addr;
            out_byte_d = CH_ZERO + 8'(head.op);
            state_d    = StOp;
          end else begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
      rec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign drop_err  = drop_q;
  assign rec_count = rec_count_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_trace_writer.sv
// Scoreboard bench for trace_writer: expected lines come from formatted-text model
// and are popped by an output monitor whenever a byte is accepted.
module tb_trace_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, drop_err;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [7:0]  out_byte;
  logic [15:0] rec_count;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_last, u_busy, u_drop_err;
  logic        u_out_ready;
  logic [3:0]  u_in_op;
  logic [31:0] u_in_addr;
  logic [7:0]  u_out_byte;
  logic [15:0] u_rec_count;

  always #5 clk = ~clk;

  trace_writer #(.FIFO_DEPTH(4), .OP_W(4), .ADDR_W(32), .UPPER_HEX(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .busy(busy), .drop_err(drop_err), .rec_count(rec_count)
  );

  trace_writer #(.FIFO_DEPTH(4), .OP_W(4), .ADDR_W(32), .UPPER_HEX(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_op(u_in_op),
    .in_addr(u_in_addr), .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_byte(u_out_byte), .out_last(u_out_last), .busy(u_busy), .drop_err(u_drop_err),
    .rec_count(u_rec_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   model_count = 0;
  int   rmode = 0;
  int   rphase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference text for one record: decimal op, space, 8 hex digits, newline.
  function automatic string line_str(input int unsigned op, input logic [31:0] addr,
                                     input bit upper);
    string s;
    s = $sformatf("%0d %08x\n", op, addr);
    if (upper) begin
      for (int i = 0; i < s.len(); i++) begin
        if (s.getc(i) >= 8'h61 && s.getc(i) <= 8'h66) s.putc(i, s.getc(i) - 8'h20);
      end
    end
    return s;
  endfunction

  function automatic void push_line(input int unsigned op, input logic [31:0] addr);
    string s;
    exp_t  e;
    s = line_str(op, addr, 1'b0);
    for (int i = 0; i < s.len(); i++) begin
      e.b    = s.getc(i);
      e.last = (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Sink readiness patterns: 0 always, 1 never, 2 toggling 1,0,0,1, 3 random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      2: begin
        out_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
        rphase++;
      end
      default: out_ready = 1'($urandom % 2);
    endcase
  end

  // Scoreboard: input handshakes push expectations, output acceptances pop them.
  bit         hold_pend = 0, cnt_pend = 0, drop_pend = 0;
  logic [7:0] hold_byte;
  logic       hold_last;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pend = 0;
      cnt_pend  = 0;
      drop_pend = 0;
    end else begin
      if (cnt_pend) check("rec_count", 32'(rec_count), 32'(model_count));
      cnt_pend = 0;
      check("drop_err", 32'(drop_err), 32'(drop_pend));
      if (hold_pend) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'(hold_byte));
        check("stall_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_byte: got %02h, expected no byte at %0t", out_byte, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", 32'(out_byte), 32'(e.b));
          check("out_last", 32'(out_last), 32'(e.last));
          if (e.last) begin
            model_count = (model_count + 1) % 65536;
            cnt_pend    = 1;
          end
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_byte = out_byte;
      hold_last = out_last;
      drop_pend = 0;
      if (in_valid && in_ready) begin
        if (in_op > 4'd9) drop_pend = 1;
        else push_line(32'(in_op), in_addr);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] addr);
    bit done = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    for (int g = 0; g < 500 && !done; g++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int g = 0; g < budget && !done; g++) begin
      @(negedge clk);
      if (!busy && !out_valid && exp_q.size() == 0) done = 1;
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    run, cnt, idx;
    bit    started, done;
    string us;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_addr = '0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_in_op = '0; u_in_addr = '0; u_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_err), 32'd0);
    check("rst_count", 32'(rec_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single record, sink always ready: latency and 11 consecutive bytes.
    rmode = 0;
    send(4'd2, 32'h1234abcd);
    @(negedge clk);
    check("lat_edge_n", 32'(out_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check("line_cont", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("line_end", 32'(out_valid), 32'd0);
    check("t1_count", 32'(rec_count), 32'd1);

    // Same record under 1,0,0,1 back-pressure.
    rmode  = 2;
    rphase = 0;
    send(4'd2, 32'h1234abcd);
    wait_idle(200);
    check("t2_count", 32'(rec_count), 32'd2);

    // Fill: one record in the output register plus four queued.
    rmode = 1;
    for (int i = 0; i < 5; i++) send(4'(i), 32'hffffffff);
    @(negedge clk);
    check("fifo_full", 32'(in_ready), 32'd0);
    rmode   = 0;
    run     = 0;
    started = 0;
    done    = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        run++;
        started = 1;
      end else if (started) done = 1;
    end
    check("no_bubble", 32'(run), 32'd55);
    check("t3_count", 32'(rec_count), 32'd7);

    // Illegal op is swallowed; then a legal boundary op.
    send(4'd12, 32'h55);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("illegal_busy", 32'(busy), 32'd0);
      check("illegal_valid", 32'(out_valid), 32'd0);
    end
    send(4'd9, 32'h0);
    wait_idle(200);
    check("t4_count", 32'(rec_count), 32'd8);

    // Reset after the 4th byte of a line.
    send(4'd5, 32'hcafef00d);
    cnt = 0;
    for (int g = 0; g < 100 && cnt < 4; g++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
    end
    check("mid_bytes", 32'(cnt), 32'd4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_count = 0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_count", 32'(rec_count), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Upper-case build.
    @(posedge clk);
    #1;
    u_in_valid = 1'b1;
    u_in_op    = 4'd7;
    u_in_addr  = 32'hdeadbeef;
    @(negedge clk);
    check("upper_in_ready", 32'(u_in_ready), 32'd1);
    @(posedge clk);
    #1 u_in_valid = 1'b0;
    us  = line_str(7, 32'hdeadbeef, 1'b1);
    idx = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (u_out_valid && u_out_ready && idx < us.len()) begin
        check("upper_byte", 32'(u_out_byte), 32'(us.getc(idx)));
        check("upper_last", 32'(u_out_last), 32'(idx == us.len() - 1));
        idx++;
      end
    end
    check("upper_len", 32'(idx), 32'd11);
    check("upper_count", 32'(u_rec_count), 32'd1);

    // Randomised records, ops and sink readiness.
    rmode = 3;
    for (int r = 0; r < 300; r++) begin
      logic [3:0] op;
      op = ($urandom % 5 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      repeat ($urandom % 4) @(posedge clk);
      send(op, $urandom);
    end
    rmode = 0;
    wait_idle(5000);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(rec_count), 32'(model_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_writer.md
Name: trace_writer

Overview:
Serialises cache event records (operation code plus 32-bit address) into an ASCII trace byte stream, one line per record, in the same "op address" text format the trace parser consumes. Example line: "2 1234abcd\n". It sits at the LLC output side and feeds a byte sink such as a log UART or a file-dump model. A small record FIFO lets the cache post events in bursts while the byte side drains at one byte per cycle.

Parameters:
FIFO_DEPTH, 4, record FIFO entries; must be a power of two and at least 2.
OP_W, 4, operation code width.
ADDR_W, 32, address width; must be a multiple of 4. Hex digit count is ADDR_W/4.
UPPER_HEX, 0, 1 emits 'A'-'F', 0 emits 'a'-'f'.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous assert, active-low reset.
in_valid  in  1  record valid.
in_ready  out  1  record accepted when in_valid && in_ready.
in_op  in  OP_W  operation code; legal values 0-9.
in_addr  in  ADDR_W  address.
out_valid  out  1  out_byte valid.
out_ready  in  1  sink accepts the byte when out_valid && out_ready.
out_byte  out  8  ASCII character.
out_last  out  1  high with the '\n' byte.
busy  out  1  FIFO non-empty or a line is in progress.
drop_err  out  1  one-cycle pulse when an illegal op record is accepted.
rec_count  out  16  count of completed lines (the '\n' byte has been accepted); wraps at 2^16.

Behaviour:
- Reset: all outputs 0 except in_ready, which is 1 after reset. FIFO is empty and the FSM is in IDLE.
- Reset mid-line: the partial line is abandoned. No newline is emitted. FIFO contents are lost.
- Input side:
  - in_ready = !fifo_full. There is no same-cycle bypass. A pop frees a slot from the next cycle onward.
  - A record with in_op > 9 is accepted (handshake completes) but not enqueued. drop_err pulses in the following cycle.
- FSM states: IDLE, OP, SPACE, HEX, EOL.
  - IDLE: if the FIFO is non-empty, pop the head, load out_byte = '0'+op, and go to OP.
  - OP: on acceptance, send ' ' (0x20) and go to SPACE.
  - SPACE: on acceptance, send the most significant nibble, set digit counter = ADDR_W/4-1, and go to HEX.
  - HEX: on acceptance, if counter > 0, decrement it and emit the next lower nibble. If counter = 0, emit '\n' (0x0A) and go to EOL.
  - EOL: on acceptance, increment rec_count. If the FIFO is non-empty, pop and load the next op digit in the same edge and go to OP (no bubble). Otherwise drop out_valid and go to IDLE.
- Nibble conversion: values 0-9 map to 0x30+n. Values 10-15 map to 0x61+n-10, or 0x41+n-10 when UPPER_HEX=1.
- Output rules:
  - out_byte and out_valid are registered.
  - While out_valid && !out_ready, out_byte, out_last and the FSM state hold stable.
  - out_valid never drops without acceptance.
- Latency and throughput:
  - A record accepted at edge N into an empty, idle block gives out_valid high after edge N+1.
  - With out_ready held high, a line takes 2+ADDR_W/4+1 = 11 cycles, back-to-back.
- Simultaneous FIFO push and pop are allowed, and the count stays unchanged.
- busy = (state != IDLE) || !fifo_empty.

Decomposition:
- Package llc_trace_pkg holds:
  - ASCII constants: CH_SPACE, CH_NL, CH_ZERO, CH_LA, CH_UA.
  - typedef trace_rec_t {op, addr}.
  - enum wr_state_e {IDLE, OP, SPACE, HEX, EOL}.
  - Function nibble_to_ascii(nibble, upper).
  - Parameter OP_MAX = 9.
- Sub-module trace_rec_fifo is a synchronous FIFO of trace_rec_t with full/empty flags, parameterised by depth.
- trace_writer holds the FSM, digit counter, output register and rec_count.

Test Plan:
- Single record, out_ready held high. Drive op=2, addr=0x1234ABCD. Required: 11 bytes 0x32 0x20 0x31 0x32 0x33 0x34 0x61 0x62 0x63 0x64 0x0A on consecutive cycles; out_last only on 0x0A; rec_count goes 0→1; first out_valid one cycle after acceptance.
- Back-pressure. Same record with out_ready toggling 1,0,0,1 repeating. Required: identical byte sequence, and out_byte stable during every stall cycle.
- Fill FIFO. Hold out_ready=0 and push 5 records (op 0-4, addr 0xFFFFFFFF). Required: in_ready low after 4 pushes plus 1 in the output register as designed; after release, lines "0 ffffffff\n" through "4 ffffffff\n" appear with no bubble between lines; rec_count=5.
- Illegal op. Drive op=12. Required: record accepted, drop_err pulses once, no bytes emitted, busy stays 0. Then op=9 addr=0 gives "9 00000000\n".
- Reset mid-line. Assert rst_n low after the 4th byte. Required: out_valid=0, rec_count=0 and in_ready=1 immediately; after release, no stray bytes are emitted.
- UPPER_HEX=1 build. Drive op=7, addr=0xDEADBEEF. Required: bytes "7 DEADBEEF\n".
